// File: rtl/amp_lj_rx.sv
// amp_lj_rx: slave-mode left-justified serial audio receiver.
// BCLK, LRCLK and SDATA are driven externally and are asynchronous to clk.
// The lines are synchronised into the clk domain, and a sample strobe is taken on
// each BCLK rising edge. The receiver captures the right word and then the left
// word, and publishes them together as a stereo pair.
//
// Output strobes: valid is a single-cycle pulse that marks the cycle in which
// dataR/dataL first hold a newly loaded pair. There is no back-pressure, so a
// consumer must take the pair in that cycle or read the held value later.
// frame_err is a single-cycle pulse on a slot that ends before dataW bits.
// valid and frame_err are never asserted in the same cycle.
module amp_lj_rx #(
  parameter int dataW       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             BCLK,
  input  logic             LRCLK,
  input  logic             SDATA,
  input  logic             enable,
  output logic [dataW-1:0] dataR,
  output logic [dataW-1:0] dataL,
  output logic             valid,
  output logic             frame_err,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  localparam int CW = $clog2(dataW + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(dataW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // LDONE is the single clk cycle that loads the finished pair into the outputs.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    RIGHT = 3'd2,
    RDONE = 3'd3,
    LEFT  = 3'd4,
    LDONE = 3'd5
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] bclk_sync, lrclk_sync, sdata_sync;
  logic bclk_s, lrclk_s, sdata_s;
  logic bclk_d;
  logic tick, lr_t, sd_t;
  logic lr_prev, lr_prev_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [dataW-1:0] sh_r, sh_r_n, sh_l, sh_l_n;
  logic [dataW-1:0] data_r_n, data_l_n;
  logic valid_n, err_n;

  // Synchronise all three serial lines through the same number of stages so
  // that they keep their relative alignment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      sdata_sync <= '0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], BCLK};
      lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], LRCLK};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], SDATA};
    end
  end

  assign bclk_s  = bclk_sync[SYNC_STAGES-1];
  assign lrclk_s = lrclk_sync[SYNC_STAGES-1];
  assign sdata_s = sdata_sync[SYNC_STAGES-1];

  // Registered rising-edge detect on the synced BCLK. The slot and data bit are
  // captured together with the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_d <= 1'b0;
      tick   <= 1'b0;
      lr_t   <= 1'b0;
      sd_t   <= 1'b0;
    end else begin
      bclk_d <= bclk_s;
      tick   <= bclk_s & ~bclk_d;
      lr_t   <= lrclk_s;
      sd_t   <= sdata_s;
    end
  end

  // Registers for the state, the counter, the shift registers and the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lr_prev   <= 1'b0;
      cnt       <= '0;
      sh_r      <= '0;
      sh_l      <= '0;
      dataR     <= '0;
      dataL     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      lr_prev   <= lr_prev_n;
      cnt       <= cnt_n;
      sh_r      <= sh_r_n;
      sh_l      <= sh_l_n;
      dataR     <= data_r_n;
      dataL     <= data_l_n;
      valid     <= valid_n;
      frame_err <= err_n;
    end
  end

  assign cnt_inc = cnt + CNT_ONE;

  // Next-state logic. Surplus bits in either slot fall through without effect.
  // The left word completes on its dataW-th bit, so a frame that is followed by a
  // stopped BCLK is still delivered.
  always_comb begin
    state_n   = state;
    lr_prev_n = lr_prev;
    cnt_n     = cnt;
    sh_r_n    = sh_r;
    sh_l_n    = sh_l;
    data_r_n  = dataR;
    data_l_n  = dataL;
    valid_n   = 1'b0;
    err_n     = 1'b0;

    if (tick && state != IDLE) lr_prev_n = lr_t;

    if (!enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: state_n = SYNC;

        SYNC: begin
          if (tick && !lr_t && lr_prev) begin
            state_n = RIGHT;
            sh_r_n  = {{(dataW-1){1'b0}}, sd_t};
            cnt_n   = CNT_ONE;
          end
        end

        RIGHT: begin
          if (tick) begin
            if (!lr_t) begin
              sh_r_n = {sh_r[dataW-2:0], sd_t};
              cnt_n  = cnt_inc;
              if (cnt_inc == CNT_FULL) state_n = RDONE;
            end else begin
              err_n   = 1'b1;
              state_n = SYNC;
            end
          end
        end

        RDONE: begin
          if (tick && lr_t) begin
            state_n = LEFT;
            sh_l_n  = {{(dataW-1){1'b0}}, sd_t};
            cnt_n   = CNT_ONE;
          end
        end

        LEFT: begin
          if (tick) begin
            if (lr_t) begin
              sh_l_n = {sh_l[dataW-2:0], sd_t};
              cnt_n  = cnt_inc;
              if (cnt_inc == CNT_FULL) state_n = LDONE;
            end else begin
              // A short left slot: this tick already starts the next right word.
              err_n   = 1'b1;
              state_n = RIGHT;
              sh_r_n  = {{(dataW-1){1'b0}}, sd_t};
              cnt_n   = CNT_ONE;
            end
          end
        end

        LDONE: begin
          data_r_n = sh_r;
          data_l_n = sh_l;
          valid_n  = 1'b1;
          state_n  = SYNC;
        end

        default: state_n = IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_amp_lj_rx.sv
// tb_amp_lj_rx: random and directed frames for amp_lj_rx.
// The reference model is defined at slot level. Once the receiver is aligned, the
// model applies these rules to each frame:
//   - A right slot shorter than dataW gives a frame_err at the first left bit,
//     and the frame is dropped.
//   - A left slot shorter than dataW gives a frame_err at the first bit of the
//     next right slot.
//   - A frame with two full slots gives a valid that carries the first dataW bits
//     of each slot.
// The model also predicts on which clk cycle each pulse appears.
module tb_amp_lj_rx;

  localparam int DW   = 12;
  localparam int SS   = 2;
  localparam int HALF = 5;
  localparam int EW   = 1 + 32 + 2 * DW;

  logic clk = 1'b0;
  logic rst, bclk, lrclk, sdata, enable;
  logic [DW-1:0] data_r, data_l;
  logic valid, frame_err, busy;
  logic [2:0] state_dbg;

  amp_lj_rx #(.dataW(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .BCLK(bclk), .LRCLK(lrclk), .SDATA(sdata),
    .enable(enable), .dataR(data_r), .dataL(data_l), .valid(valid),
    .frame_err(frame_err), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each entry is {is_valid, expected_cycle, right, left}.
  logic [EW-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;
  logic pend_lerr = 1'b0;
  logic [DW-1:0] last_r = '0, last_l = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One BCLK period. LRCLK and SDATA change at the falling edge. On the rising
  // edge, the expected pulse for that bit is queued (0 none, 1 err, 2 valid).
  task automatic drive_bit(input logic lr, input logic b, input int kind,
                           input logic [DW-1:0] r, input logic [DW-1:0] l);
    @(posedge clk); #1;
    bclk = 1'b0; lrclk = lr; sdata = b;
    repeat (HALF) @(posedge clk);
    #1;
    bclk = 1'b1;
    if (kind == 1) exp_q.push_back({1'b0, 32'(cyc + SS + 2), {(2*DW){1'b0}}});
    if (kind == 2) exp_q.push_back({1'b1, 32'(cyc + SS + 3), r, l});
    repeat (HALF - 1) @(posedge clk);
  endtask

  task automatic drive_plain(input logic lr, input int n);
    for (int i = 0; i < n; i++) drive_bit(lr, 1'($urandom_range(0, 1)), 0, '0, '0);
  endtask

  task automatic drive_frame(input logic [31:0] rw, input int rlen,
                             input logic [31:0] lw, input int llen);
    logic [DW-1:0] rword, lword;
    int k;
    rword = '0;
    lword = '0;
    if (rlen >= DW) rword = DW'(rw >> (rlen - DW));
    if (llen >= DW) lword = DW'(lw >> (llen - DW));
    for (int i = 0; i < rlen; i++) begin
      k = (i == 0 && pend_lerr) ? 1 : 0;
      if (k == 1) pend_lerr = 1'b0;
      drive_bit(1'b0, rw[rlen-1-i], k, '0, '0);
    end
    for (int i = 0; i < llen; i++) begin
      k = 0;
      if (rlen < DW && i == 0) k = 1;
      if (rlen >= DW && llen >= DW && i == DW - 1) k = 2;
      drive_bit(1'b1, lw[llen-1-i], k, rword, lword);
    end
    if (rlen >= DW && llen < DW) pend_lerr = 1'b1;
  endtask

  function automatic int pick_len();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return $urandom_range(1, DW - 1);
    if (r < 4) return DW + $urandom_range(1, 4);
    return DW;
  endfunction

  // Monitor: pop and compare on every pulse, and check that outputs hold otherwise.
  logic [EW-1:0] mon_e;
  logic mon_pop;
  always @(negedge clk) begin
    if (rst) begin
      last_r = '0;
      last_l = '0;
    end else begin
      mon_pop = 1'b0;
      if (valid && frame_err) check("valid_err_overlap", 64'(1), 64'(0));
      if (valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 64'({valid, frame_err}), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          mon_pop = 1'b1;
          check("pulse_kind", 64'(valid), 64'(mon_e[EW-1]));
          check("pulse_cycle", 64'(cyc), 64'(mon_e[EW-2 -: 32]));
          if (valid) begin
            check("dataR", 64'(data_r), 64'(mon_e[2*DW-1 -: DW]));
            check("dataL", 64'(data_l), 64'(mon_e[DW-1:0]));
          end
        end
        if (valid && mon_pop && mon_e[EW-1]) begin
          last_r = mon_e[2*DW-1 -: DW];
          last_l = mon_e[DW-1:0];
        end
      end
      if (!valid) begin
        check("dataR_hold", 64'(data_r), 64'(last_r));
        check("dataL_hold", 64'(data_l), 64'(last_l));
      end
    end
  end

  // Stimulus sequence and final report.
  initial begin
    rst = 1'b1; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dataR", 64'(data_r), 64'(0));
    check("rst_dataL", 64'(data_l), 64'(0));
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_frame_err", 64'(frame_err), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    enable = 1'b1;
    drive_plain(1'b1, 3);

    // Two plain frames.
    drive_frame(32'hA5C, 12, 32'h3F1, 12);
    drive_frame(32'h001, 12, 32'h800, 12);
    // Surplus bits in both slots.
    drive_frame({19'd0, 12'hA5C, 1'b1}, 13, {16'd0, 12'h3F1, 4'hA}, 16);
    // Short right slot, then a good frame.
    drive_frame(32'h55, 7, 32'h777, 12);
    drive_frame(32'h5A5, 12, 32'h1E3, 12);
    // Short left slot, then a good frame.
    drive_frame(32'h111, 12, 32'h15, 5);
    drive_frame(32'h123, 12, 32'h456, 12);

    // Drop enable mid right slot.
    drive_plain(1'b0, 6);
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("busy_after_disable", 64'(busy), 64'(0));
    check("dataR_after_disable", 64'(data_r), 64'(12'h123));
    check("dataL_after_disable", 64'(data_l), 64'(12'h456));
    drive_plain(1'b0, 4);
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("busy_after_enable", 64'(busy), 64'(1));
    drive_plain(1'b1, 3);
    drive_frame(32'h9C3, 12, 32'h2B7, 12);

    // Reset in the middle of a left slot.
    drive_plain(1'b0, 12);
    drive_plain(1'b1, 5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_dataR", 64'(data_r), 64'(0));
    check("midrst_dataL", 64'(data_l), 64'(0));
    check("midrst_valid", 64'(valid), 64'(0));
    check("midrst_frame_err", 64'(frame_err), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    pend_lerr = 1'b0;
    drive_plain(1'b1, 4);
    drive_frame(32'hFFF, 12, 32'h000, 12);

    // Random frames.
    for (int f = 0; f < 30; f++) drive_frame($urandom, pick_len(), $urandom, pick_len());
    drive_frame($urandom, 12, $urandom, 12);

    repeat (20) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/amp_lj_rx.md
Name: amp_lj_rx

Overview:
- Slave-mode receiver for left-justified serial audio: BCLK, LRCLK and SDATA are all driven externally.
- Counterpart of the team's AMP3 left-justified transmitter; used for loopback verification and for ADC-style Pmods.
- Synchronises the three serial lines into the clk domain, deserialises the right word then the left word, and presents a stereo pair with a one-cycle valid strobe.

Parameters:
- dataW, 12, bits captured per channel; MSB first; must be ≥2.
- SYNC_STAGES, 2, flip-flop synchroniser depth per serial input; must be ≥2.

Ports:
- clk  in  1  system clock; must be ≥4× the BCLK frequency (100 MHz vs 5 MHz nominal).
- rst  in  1  reset.
- BCLK  in  1  serial bit clock, asynchronous to clk.
- LRCLK  in  1  channel select: 0 = right slot, 1 = left slot.
- SDATA  in  1  serial data; changes on BCLK falling edge, sampled on BCLK rising edge.
- enable  in  1  receiver enable, level-sensitive.
- dataR  out  dataW  last complete right word.
- dataL  out  dataW  last complete left word.
- valid  out  1  one-clk pulse when a new pair is loaded.
- frame_err  out  1  one-clk pulse on a short slot.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. Reset clears dataR, dataL, valid, frame_err, busy, all shift registers, counters and synchronisers, and sets state to IDLE. Reset mid-frame discards the partial frame with no valid.
- Input sampling:
  - BCLK, LRCLK and SDATA each pass through SYNC_STAGES flops; all three have equal delay.
  - A registered rising-edge detect on synced BCLK produces the sample strobe `tick`.
  - At `tick`, `lr` = synced LRCLK and `bit` = synced SDATA; `lr_prev` holds the lr from the previous tick.
  - `lr_prev` resets to 0 and is updated on every tick in every state except IDLE.
- Bit counter: cnt is $clog2(dataW+1) bits wide. The shift register shifts left, taking `bit` into the LSB.
- States and transitions:
  - IDLE
    - enable=1 → SYNC.
  - SYNC (align to a right-slot start)
    - tick with lr=0 and lr_prev=1 → RIGHT; bit loaded; cnt=1.
  - RIGHT
    - tick with lr=0: shift, cnt+1; when cnt reaches dataW → RDONE.
    - tick with lr=1 before cnt==dataW → frame_err pulse; → SYNC; partial right word discarded.
  - RDONE
    - tick with lr=0: surplus bit ignored.
    - tick with lr=1 → LEFT; bit loaded; cnt=1.
  - LEFT
    - tick with lr=1: shift, cnt+1; on reaching dataW, next clk loads dataR and dataL, pulses valid, → SYNC.
    - tick with lr=0 before full → frame_err pulse; that tick is treated as a right-slot start (→ RIGHT, bit loaded, cnt=1).
- Surplus bits: bits beyond dataW in either slot are ignored, which covers transmitters that send dataW+1 bits or idle-low padding. Because the left word completes on its dataW-th bit, a final frame followed by a stopped BCLK (LRCLK left high) is still delivered.
- Latency: valid asserts exactly SYNC_STAGES+2 clk cycles after the first clk edge that samples pin BCLK high on the final left bit.
- Output hold: dataR and dataL change only on valid and otherwise hold. valid and frame_err are never high in the same cycle.
- enable=0 in any state → IDLE at the next clk edge. Partial data is discarded, no valid or frame_err is issued, and outputs keep their last values.
- BCLK stopped mid-slot: the block waits indefinitely. There is no timeout; enable or rst recovers it.

Test Plan:
- Two frames, right 0xA5C / left 0x3F1 then right 0x001 / left 0x800, dataW=12 → valid pulses twice; outputs hold each pair in turn; frame_err stays 0.
- Right slot of 13 bits (extra trailing 1) and left slot of 16 bits → dataR=0xA5C, dataL=0x3F1; surplus ignored.
- Right slot of only 7 bits, then LRCLK rises → frame_err pulse; no valid; the next full frame is received correctly.
- Left slot cut at 5 bits by LRCLK falling → frame_err; the following right word 0x123 plus left 0x456 → valid with those values.
- enable dropped after 6 right bits → busy=0 next clk; previous dataR/dataL unchanged; re-enable resynchronises on the next right-slot start.
- rst pulsed mid left slot → all outputs 0; no valid until a complete new frame is received.
